// File: rtl/alu_operand_stage_if.sv
// Handshake bundle between decode, writeback forwarding and the ALU.
// master: decode/ALU side (drives in_*, fwd_*, flush, out_ready); slave: the stage.
interface alu_operand_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) ();
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_rs1_data;
    logic [DATA_WIDTH-1:0] in_rs2_data;
    logic [REG_ADDR_W-1:0] in_rs1_addr;
    logic [REG_ADDR_W-1:0] in_rs2_addr;
    logic [DATA_WIDTH-1:0] in_pc;
    logic [DATA_WIDTH-1:0] in_imm;
    logic [1:0]            in_a_sel;
    logic [1:0]            in_b_sel;
    logic [2:0]            in_alu_op;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_rd;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [2:0]            alu_op;
    logic [REG_ADDR_W-1:0] out_rd;

    modport master (
        output flush, in_valid, in_rs1_data, in_rs2_data,
        output in_rs1_addr, in_rs2_addr, in_pc, in_imm,
        output in_a_sel, in_b_sel, in_alu_op, in_rd,
        output fwd_valid, fwd_rd, fwd_data, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_op, out_rd
    );

    modport slave (
        input  flush, in_valid, in_rs1_data, in_rs2_data,
        input  in_rs1_addr, in_rs2_addr, in_pc, in_imm,
        input  in_a_sel, in_b_sel, in_alu_op, in_rd,
        input  fwd_valid, fwd_rd, fwd_data, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_op, out_rd
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Registered ALU issue stage: main + skid entry, operand select, WB forwarding.
// Ports: clk, rst_n (async active-low), bus (slave view of alu_operand_stage_if).
module alu_operand_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_operand_stage_if.slave bus
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] rs1_data;
        logic [DATA_WIDTH-1:0] rs2_data;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] imm;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [REG_ADDR_W-1:0] rd;
        logic [1:0]            a_sel;
        logic [1:0]            b_sel;
        logic [2:0]            alu_op;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_n;
    entry_t main_q, main_n;
    entry_t skid_q, skid_n;
    entry_t in_e;
    logic   accept;
    logic   consume;

    // Entries keep raw register values so a later writeback can still patch them.
    function automatic entry_t fwd(
        input entry_t                e,
        input logic                  v,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [DATA_WIDTH-1:0] d
    );
        entry_t r;
        r = e;
        if (v && rd != '0 && rd == e.rs1_addr) r.rs1_data = d;
        if (v && rd != '0 && rd == e.rs2_addr) r.rs2_data = d;
        return r;
    endfunction

    always_comb begin
        in_e          = '0;
        in_e.rs1_data = bus.in_rs1_data;
        in_e.rs2_data = bus.in_rs2_data;
        in_e.pc       = bus.in_pc;
        in_e.imm      = bus.in_imm;
        in_e.rs1_addr = bus.in_rs1_addr;
        in_e.rs2_addr = bus.in_rs2_addr;
        in_e.rd       = bus.in_rd;
        in_e.a_sel    = bus.in_a_sel;
        in_e.b_sel    = bus.in_b_sel;
        in_e.alu_op   = bus.in_alu_op;
    end

    assign accept  = bus.in_valid && (state_q != FULL);
    assign consume = (state_q != EMPTY) && bus.out_ready;

    always_comb begin
        entry_t in_f;
        entry_t main_f;
        entry_t skid_f;
        in_f    = fwd(in_e, bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
        main_f  = fwd(main_q, bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
        skid_f  = fwd(skid_q, bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
        state_n = state_q;
        main_n  = main_f;
        skid_n  = skid_f;
        if (bus.flush) begin
            state_n = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_n  = in_f;
                        state_n = ONE;
                    end
                end
                ONE: begin
                    if (consume && accept) begin
                        main_n = in_f;
                    end else if (consume) begin
                        state_n = EMPTY;
                    end else if (accept) begin
                        skid_n  = in_f;
                        state_n = FULL;
                    end
                end
                FULL: begin
                    if (consume) begin
                        main_n  = skid_f;
                        state_n = ONE;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_n;
            main_q  <= main_n;
            skid_q  <= skid_n;
        end
    end

    // Reserved selects fall through to zero.
    always_comb begin
        bus.alu_a = '0;
        unique case (main_q.a_sel)
            2'd0:    bus.alu_a = main_q.rs1_data;
            2'd1:    bus.alu_a = main_q.pc;
            default: bus.alu_a = '0;
        endcase
    end

    always_comb begin
        bus.alu_b = '0;
        unique case (main_q.b_sel)
            2'd0:    bus.alu_b = main_q.rs2_data;
            2'd1:    bus.alu_b = main_q.imm;
            2'd2:    bus.alu_b = DATA_WIDTH'(4);
            default: bus.alu_b = '0;
        endcase
    end

    assign bus.alu_op    = main_q.alu_op;
    assign bus.out_rd    = main_q.rd;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.in_ready  = (state_q != FULL);
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with an expected-bundle queue.
// Ports: none; drives the stage through an alu_operand_stage_if instance.
module tb_alu_operand_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_operand_stage_if bus ();

    alu_operand_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  rd;
    } exp_t;

    exp_t q[$];
    exp_t mon_got;
    exp_t mon_exp;
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic logic [31:0] sel_a(input logic [1:0] s,
                                          input logic [31:0] rs1,
                                          input logic [31:0] pc);
        case (s)
            2'd0:    return rs1;
            2'd1:    return pc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] sel_b(input logic [1:0] s,
                                          input logic [31:0] rs2,
                                          input logic [31:0] imm);
        case (s)
            2'd0:    return rs2;
            2'd1:    return imm;
            2'd2:    return 32'd4;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // rs1_x/rs2_x: the register values the entry should hold when it reaches the ALU.
    task automatic issue(
        input logic [31:0] rs1, input logic [31:0] rs2,
        input logic [4:0]  a1,  input logic [4:0]  a2,
        input logic [31:0] pc,  input logic [31:0] imm,
        input logic [1:0]  as,  input logic [1:0]  bs,
        input logic [2:0]  op,  input logic [4:0]  rd,
        input logic [31:0] rs1_x, input logic [31:0] rs2_x
    );
        int   tries;
        logic acc;
        exp_t e;
        tries           = 0;
        bus.in_rs1_data = rs1;
        bus.in_rs2_data = rs2;
        bus.in_rs1_addr = a1;
        bus.in_rs2_addr = a2;
        bus.in_pc       = pc;
        bus.in_imm      = imm;
        bus.in_a_sel    = as;
        bus.in_b_sel    = bs;
        bus.in_alu_op   = op;
        bus.in_rd       = rd;
        bus.in_valid    = 1'b1;
        do begin
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            tries++;
        end while (!acc && tries < 20);
        bus.in_valid = 1'b0;
        n_chk++;
        assert (acc === 1'b1) else begin
            n_fail++;
            $error("FAIL accept_timeout observed=%b expected=1", acc);
        end
        if (acc) begin
            e.a  = sel_a(as, rs1_x, pc);
            e.b  = sel_b(bs, rs2_x, imm);
            e.op = op;
            e.rd = rd;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_chk++;
        assert (q.size() == 0) else begin
            n_fail++;
            $error("FAIL drain_timeout observed=%0d expected=0", q.size());
        end
    endtask

    // A bundle is consumed on the next rising edge when valid & ready hold here.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            mon_got = '{bus.alu_a, bus.alu_b, bus.alu_op, bus.out_rd};
            n_chk++;
            assert (q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_out observed=%h expected=none", mon_got);
            end
            if (q.size() != 0) begin
                mon_exp = q.pop_front();
                n_chk++;
                assert (mon_got === mon_exp) else begin
                    n_fail++;
                    $error("FAIL out_bundle observed a=%h b=%h op=%h rd=%h expected a=%h b=%h op=%h rd=%h",
                           mon_got.a, mon_got.b, mon_got.op, mon_got.rd,
                           mon_exp.a, mon_exp.b, mon_exp.op, mon_exp.rd);
                end
            end
        end
    end

    initial begin
        bus.flush       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_rs1_data = '0;
        bus.in_rs2_data = '0;
        bus.in_rs1_addr = '0;
        bus.in_rs2_addr = '0;
        bus.in_pc       = '0;
        bus.in_imm      = '0;
        bus.in_a_sel    = '0;
        bus.in_b_sel    = '0;
        bus.in_alu_op   = '0;
        bus.in_rd       = '0;
        bus.fwd_valid   = 1'b0;
        bus.fwd_rd      = '0;
        bus.fwd_data    = '0;
        bus.out_ready   = 1'b0;

        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_alu_b", bus.alu_b, 32'd0);
        chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
        chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single op, next-cycle latency
        bus.out_ready = 1'b1;
        issue(32'h5, 32'h0, 5'd1, 5'd2, 32'h0, 32'hFFFF_FFFD,
              2'd0, 2'd1, 3'b000, 5'd9, 32'h5, 32'h0);
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        chk("single_consumed", 32'(bus.out_valid), 32'd0);

        // backpressure: two fill the stage, third waits
        bus.out_ready = 1'b0;
        issue(32'h11, 32'h21, 5'd1, 5'd2, 32'h0, 32'h0,
              2'd0, 2'd0, 3'b001, 5'd10, 32'h11, 32'h21);
        chk("bp_ready_one", 32'(bus.in_ready), 32'd1);
        issue(32'h12, 32'h22, 5'd1, 5'd2, 32'h0, 32'h0,
              2'd0, 2'd0, 3'b010, 5'd11, 32'h12, 32'h22);
        chk("bp_ready_full", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        issue(32'h13, 32'h23, 5'd1, 5'd2, 32'h0, 32'h0,
              2'd0, 2'd0, 3'b011, 5'd12, 32'h13, 32'h23);
        drain();

        // forward at accept, and x0 never forwards
        bus.fwd_valid = 1'b1;
        bus.fwd_rd    = 5'd7;
        bus.fwd_data  = 32'hABCD;
        issue(32'h0, 32'h11, 5'd0, 5'd7, 32'h0, 32'h0,
              2'd2, 2'd0, 3'b100, 5'd13, 32'h0, 32'hABCD);
        bus.fwd_rd = 5'd0;
        issue(32'h0, 32'h22, 5'd0, 5'd0, 32'h0, 32'h0,
              2'd2, 2'd0, 3'b101, 5'd14, 32'h0, 32'h22);
        bus.fwd_valid = 1'b0;
        drain();

        // forward into the stalled skid entry
        bus.out_ready = 1'b0;
        issue(32'h100, 32'h200, 5'd1, 5'd2, 32'h0, 32'h0,
              2'd0, 2'd0, 3'b110, 5'd15, 32'h100, 32'h200);
        issue(32'h9, 32'h7, 5'd3, 5'd4, 32'h0, 32'h0,
              2'd0, 2'd0, 3'b111, 5'd16, 32'h55, 32'h7);
        bus.fwd_valid = 1'b1;
        bus.fwd_rd    = 5'd3;
        bus.fwd_data  = 32'h55;
        @(posedge clk);
        #1;
        bus.fwd_valid = 1'b0;
        chk("stall_full", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        drain();

        // PC+4 and reserved selects
        issue(32'hDEAD, 32'hBEEF, 5'd5, 5'd6, 32'h0000_1000, 32'h0,
              2'd1, 2'd2, 3'b000, 5'd17, 32'hDEAD, 32'hBEEF);
        issue(32'hDEAD, 32'hBEEF, 5'd5, 5'd6, 32'h0000_2000, 32'h77,
              2'd3, 2'd3, 3'b010, 5'd18, 32'hDEAD, 32'hBEEF);
        drain();

        // flush from FULL with a pending op
        bus.out_ready = 1'b0;
        issue(32'h31, 32'h41, 5'd1, 5'd2, 32'h0, 32'h0,
              2'd0, 2'd0, 3'b001, 5'd19, 32'h31, 32'h41);
        issue(32'h32, 32'h42, 5'd1, 5'd2, 32'h0, 32'h0,
              2'd0, 2'd0, 3'b001, 5'd20, 32'h32, 32'h42);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        chk("flush_full_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        q.delete();
        chk("flush_full_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_full_inrdy", 32'(bus.in_ready), 32'd1);

        // flush from ONE discards the same-cycle accept
        issue(32'h33, 32'h43, 5'd1, 5'd2, 32'h0, 32'h0,
              2'd0, 2'd0, 3'b001, 5'd21, 32'h33, 32'h43);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        chk("flush_one_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        q.delete();
        chk("flush_one_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("flush_one_idle", 32'(bus.out_valid), 32'd0);

        // asynchronous reset while ONE
        issue(32'h34, 32'h44, 5'd1, 5'd2, 32'h0, 32'h0,
              2'd0, 2'd0, 3'b011, 5'd22, 32'h34, 32'h44);
        chk("arst_pre_valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_alu_a", bus.alu_a, 32'd0);
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // recovery
        bus.out_ready = 1'b1;
        issue(32'h35, 32'h45, 5'd1, 5'd2, 32'h0, 32'h0,
              2'd0, 2'd0, 3'b100, 5'd23, 32'h35, 32'h45);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Registered issue stage directly upstream of the 32-bit ALU. Accepts decoded micro-ops from decode and selects operands A and B from rs1/rs2/PC/immediate.
- Applies writeback forwarding and presents a stable {A, B, ALUop} bundle to the ALU under a valid/ready handshake.
- A two-entry skid buffer decouples the decode ready path from the downstream stall.

Parameters:
- DATA_WIDTH, 32, operand width; must match the ALU.
- REG_ADDR_W, 5, register-address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all buffered entries (branch redirect).
- in_valid  in  1  decode presents a micro-op.
- in_ready  out  1  stage can accept a micro-op.
- in_rs1_data  in  DATA_WIDTH  register-file read port 1.
- in_rs2_data  in  DATA_WIDTH  register-file read port 2.
- in_rs1_addr  in  REG_ADDR_W  source 1 index, used for forwarding match.
- in_rs2_addr  in  REG_ADDR_W  source 2 index, used for forwarding match.
- in_pc  in  DATA_WIDTH  micro-op PC.
- in_imm  in  DATA_WIDTH  sign-extended immediate.
- in_a_sel  in  2  0=rs1, 1=pc, 2=zero, 3=reserved (treated as zero).
- in_b_sel  in  2  0=rs2, 1=imm, 2=constant 4, 3=reserved (treated as zero).
- in_alu_op  in  3  ALUop encoding, passed through unchanged.
- in_rd  in  REG_ADDR_W  destination register.
- fwd_valid  in  1  writeback is committing a value this cycle.
- fwd_rd  in  REG_ADDR_W  writeback destination.
- fwd_data  in  DATA_WIDTH  writeback value.
- out_valid  out  1  ALU bundle valid.
- out_ready  in  1  ALU/downstream consumes the bundle.
- alu_a  out  DATA_WIDTH  operand A to the ALU.
- alu_b  out  DATA_WIDTH  operand B to the ALU.
- alu_op  out  3  ALUop to the ALU.
- out_rd  out  REG_ADDR_W  destination register, travels with the bundle.

Behaviour:
- Reset (rst_n low, asynchronous): main_valid=0, skid_valid=0, so out_valid=0 and in_ready=1. alu_a, alu_b, alu_op and out_rd are 0. Recovery is synchronous to clk.
- Storage:
  - Main register drives the outputs directly (registered outputs, no combinational path from in_* to alu_*).
  - The skid register holds one overflow entry.
  - Each entry stores its rs1/rs2 register values and addresses, not the selected operands, so forwarding can still update them.
- in_ready = ~skid_valid (registered; no combinational dependence on out_ready).
- Accept when in_valid & in_ready. Consume when out_valid & out_ready.
- Per-cycle transitions (flush=0):
  - EMPTY (main=0, skid=0): accept → main.
  - ONE (main=1, skid=0):
    - consume & accept → new entry into main.
    - consume only → EMPTY.
    - accept only → entry into skid (FULL).
  - FULL (main=1, skid=1): in_ready=0. Consume → skid moves to main (ONE). No accept is possible.
- Latency: an accepted micro-op appears on alu_* the next cycle when the stage was EMPTY, or when ONE with consume.
- Operand select is computed from the stored entry's fields, and alu_a/alu_b reflect the main entry. PC+4 style ops use a_sel=1, b_sel=2.
- Forwarding:
  - Applies when fwd_valid, fwd_rd≠0 and fwd_rd equals a source address.
  - Applied to incoming data at accept time and to every stored valid entry each cycle, so stalled entries never hold stale operands.
  - Applied independently to rs1 and rs2; both may match the same fwd_rd.
  - Register x0 never forwards; its value is whatever the register file supplies (0).
- Simultaneous forward and accept: the forwarded value is written in place of the register-file value in the same edge.
- flush=1: main_valid and skid_valid clear on the next edge.
  - Any same-cycle accept is discarded, but in_ready still reads its pre-flush value.
  - Flush has priority over consume and accept.
- Mid-operation reset clears both entries immediately, regardless of clock.
- alu_op and out_rd are unmodified copies. No arithmetic is performed here beyond the constant 4.

Test Plan:
- Reset then single op: rs1=0x0000_0005, imm=0xFFFF_FFFD, a_sel=0, b_sel=1, alu_op=000, out_ready=1 → next cycle out_valid=1, alu_a=5, alu_b=0xFFFF_FFFD, alu_op=000; after consume out_valid=0.
- Backpressure: out_ready=0, issue 3 ops back-to-back → ops 1 and 2 accepted, in_ready=0 from the cycle after op 2. Raise out_ready → op1, op2, op3 emerge in order with no loss or duplication.
- Forward on accept: in_rs2_addr=7, in_rs2_data=0x11, fwd_valid=1, fwd_rd=7, fwd_data=0xABCD, b_sel=0 → alu_b=0xABCD. Same with fwd_rd=0 and rs2_addr=0 → alu_b keeps the register-file value.
- Forward while stalled: entry in FULL skid with rs1_addr=3, forward rd=3 data=0x55 while out_ready=0 → when the entry reaches main, alu_a=0x55.
- PC+4: pc=0x0000_1000, a_sel=1, b_sel=2 → alu_a=0x1000, alu_b=4.
- Flush and async reset: FULL state, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, nothing accepted. Drop rst_n mid-cycle while ONE → out_valid=0 immediately, before the next edge.
